pwm_output_stage: RTL and testbench

//  Consumes the five configuration registers written over SPI (output enables, PWM enables, duty cycle).

---
 rtl/pwm_output_stage.sv | 127 ++++++++++++
 tb/tb_pwm_output_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_output_stage
//  Description : Sixteen-output driver that follows the SPI register file.
//                Each output is forced low, held high or driven by one
//                shared 8-bit PWM waveform. A prescaler divides clk by
//                CLK_DIV to produce PWM ticks. One PWM period is 256 ticks.
//  Option      : PWM_SHADOW_EN. When defined, duty and enables are captured
//                into shadow registers once per period. This makes config
//                changes glitch-free at period boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module pwm_output_stage #(
  parameter int CLK_DIV = 3000,
  parameter int NUM_OUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  // A divide-by-one prescaler still needs a 1-bit counter. That bit stays at 0.
  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [7:0]       pwm_cnt;
  logic             pwm_sig;
  logic [15:0]      nxt;

  // Configuration actually used by the waveform and select logic.
  logic [7:0]       duty_use;
  logic [15:0]      en_out_use;
  logic [15:0]      en_pwm_use;

  assign tick = (div_cnt == DIV_LAST);

  // Prescaler: counts 0..CLK_DIV-1 and issues one tick per wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // PWM counter advances once per tick and wraps 255->0 on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= 8'h00;
    end else if (tick) begin
      pwm_cnt <= pwm_cnt + 8'h01;
    end
  end

  // period_start is high in the clk where pwm_cnt has just become 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_start <= 1'b0;
    end else begin
      period_start <= tick && (pwm_cnt == 8'hFF);
    end
  end

`ifdef PWM_SHADOW_EN
  logic [7:0]  duty_sh;
  logic [15:0] en_out_sh;
  logic [15:0] en_pwm_sh;

  // Shadows reload only at the period boundary, so every period sees one
  // consistent configuration. They reset to 0, which keeps the outputs low
  // until the first boundary after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_sh   <= 8'h00;
      en_out_sh <= 16'h0000;
      en_pwm_sh <= 16'h0000;
    end else if (period_start) begin
      duty_sh   <= pwm_duty_cycle;
      en_out_sh <= {en_reg_out_15_8, en_reg_out_7_0};
      en_pwm_sh <= {en_reg_pwm_15_8, en_reg_pwm_7_0};
    end
  end

  assign duty_use   = duty_sh;
  assign en_out_use = en_out_sh;
  assign en_pwm_use = en_pwm_sh;
`else
  // Configuration goes straight through. A mid-period duty change can
  // stretch or shorten the pulse of that period.
  assign duty_use   = pwm_duty_cycle;
  assign en_out_use = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm_use = {en_reg_pwm_15_8, en_reg_pwm_7_0};
`endif

  // A full-scale duty is forced high. Without this, the single tick where
  // pwm_cnt == 255 would give a one-tick low glitch.
  assign pwm_sig = (duty_use == 8'hFF) | (pwm_cnt < duty_use);

  // Per-output select: disabled -> 0, enabled static -> 1, enabled PWM -> pwm_sig.
  generate
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_sel
      assign nxt[i] = en_out_use[i] ? (en_pwm_use[i] ? pwm_sig : 1'b1) : 1'b0;
    end
  endgenerate

  // Register the outputs so the pins are glitch-free and change one clk
  // after their cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= 16'h0000;
    end else begin
      out <= nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pwm_output_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_output_stage
//  Description : Directed bench for pwm_output_stage with CLK_DIV=4, giving a
//                1024-clk PWM period. Static select cases come from a vector
//                table. Period, duty and reset behaviour are checked by
//                hand-written sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_output_stage;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0]  pwm_duty_cycle;
  logic [15:0] out;
  logic        period_start;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [7:0]  duty;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [8];

  pwm_output_stage #(.CLK_DIV(CLK_DIV), .NUM_OUT(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .en_reg_out_7_0  (en_reg_out_7_0),
    .en_reg_out_15_8 (en_reg_out_15_8),
    .en_reg_pwm_7_0  (en_reg_pwm_7_0),
    .en_reg_pwm_15_8 (en_reg_pwm_15_8),
    .pwm_duty_cycle  (pwm_duty_cycle),
    .out             (out),
    .period_start    (period_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_cfg(input logic [15:0] eo, input logic [15:0] ep, input logic [7:0] d);
    en_reg_out_7_0  = eo[7:0];
    en_reg_out_15_8 = eo[15:8];
    en_reg_pwm_7_0  = ep[7:0];
    en_reg_pwm_15_8 = ep[15:8];
    pwm_duty_cycle  = d;
  endtask

  // Step clk by clk until period_start is seen, sampling on the falling edge.
  // Returns the number of rising edges taken.
  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!period_start && n < 2 * PERIOD + 100);
    if (!period_start) begin
      checks++;
      errors++;
      $display("FAIL period_start_timeout: actual=none after %0d clk required=pulse", n);
    end
  endtask

  // Wait until a new configuration is visible on out.
  task automatic settle;
`ifdef PWM_SHADOW_EN
    int n;
    wait_ps(n);
    @(negedge clk);
    @(negedge clk);
`else
    @(negedge clk);
`endif
  endtask

  // Observe one full period, starting at the period_start sample.
  // highs counts clks with the PWM group high. bad counts clks where out is
  // not exactly (PWM group at one common level) | static group.
  task automatic measure(input logic [15:0] pwm_mask, input logic [15:0] static_mask,
                         output int highs, output int bad,
                         output logic [15:0] s0, output logic [15:0] s1);
    int n;
    logic lvl;
    logic [15:0] exp;
    wait_ps(n);
    highs = 0;
    bad   = 0;
    s0    = '0;
    s1    = '0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) s0 = out;
      if (i == 1) s1 = out;
      lvl = |(out & pwm_mask);
      exp = (lvl ? pwm_mask : 16'h0000) | static_mask;
      if (out !== exp) bad++;
      if (lvl) highs++;
    end
  endtask

  initial begin
    int n, h, b, h1, h2, hs;
    logic [15:0] s0, s1, prev;

    vecs[0] = '{16'h00FF, 16'h0000, 8'h80, 16'h00FF};
    vecs[1] = '{16'h0000, 16'h0000, 8'h80, 16'h0000};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 8'h00, 16'h0000};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 8'hFF, 16'hFFFF};
    vecs[4] = '{16'hFFFF, 16'h00FF, 8'h00, 16'hFF00};
    vecs[5] = '{16'hA5A5, 16'h0F0F, 8'hFF, 16'hA5A5};
    vecs[6] = '{16'hA5A5, 16'h0F0F, 8'h00, 16'hA0A0};
    vecs[7] = '{16'h1234, 16'h0000, 8'h00, 16'h1234};

    // Reset held with everything enabled.
    rst_n = 1'b0;
    set_cfg(16'hFFFF, 16'hFFFF, 8'h80);
    repeat (3) @(negedge clk);
    check("reset_out", {16'h0, out}, 32'h0);
    check("reset_period_start", {31'h0, period_start}, 32'h0);

    // First period_start comes 256*CLK_DIV clk after release, then every period.
    rst_n = 1'b1;
    wait_ps(n);
    check("first_period_start", n, PERIOD);
    wait_ps(n);
    check("period_spacing", n, PERIOD);

    // Static select table. Here out is 0 because pwm_cnt was 255 with duty 80.
    prev = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      set_cfg(vecs[i].en_out, vecs[i].en_pwm, vecs[i].duty);
`ifdef PWM_SHADOW_EN
      wait_ps(n);
      @(negedge clk);
      @(negedge clk);
`else
      #1;
      check($sformatf("vec%0d_latency", i), {16'h0, out}, {16'h0, prev});
      @(negedge clk);
`endif
      check($sformatf("vec%0d_out", i), {16'h0, out}, {16'h0, vecs[i].exp});
      prev = vecs[i].exp;
    end

    // Duty 0x40: 64 ticks high per period, all bits identical.
    set_cfg(16'hFFFF, 16'hFFFF, 8'h40);
    settle();
    measure(16'hFFFF, 16'h0000, h, b, s0, s1);
    check("duty40_highs", h, 256);
    check("duty40_aligned", b, 0);
    check("duty40_at_period_start", {16'h0, s0}, 32'h0);
    check("duty40_after_period_start", {16'h0, s1}, 32'hFFFF);

    // Duty change 40->C0 at pwm_cnt 0x10.
    wait_ps(n);
    check("ps_spacing_duty40", n, 1);
    h1 = 0;
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      if (out[0]) h1++;
      if (i == 16 * CLK_DIV) pwm_duty_cycle = 8'hC0;
    end
    measure(16'hFFFF, 16'h0000, h2, b, s0, s1);
`ifdef PWM_SHADOW_EN
    check("duty_change_current", h1, 256);
`else
    check("duty_change_current", h1, 768);
`endif
    check("duty_change_next", h2, 768);

    // One-tick boundaries: duty 01 and duty FE.
    set_cfg(16'hFFFF, 16'hFFFF, 8'h01);
    settle();
    measure(16'hFFFF, 16'h0000, h, b, s0, s1);
    check("duty01_highs", h, CLK_DIV);
    set_cfg(16'hFFFF, 16'hFFFF, 8'hFE);
    settle();
    measure(16'hFFFF, 16'h0000, h, b, s0, s1);
    check("dutyFE_highs", h, 254 * CLK_DIV);

    // Mixed: 15:12 PWM 50%, 7:4 static high, others low.
    set_cfg(16'hF0F0, 16'hFF00, 8'h80);
    settle();
    measure(16'hF000, 16'h00F0, h, b, s0, s1);
    check("mixed_highs", h, 512);
    check("mixed_pattern", b, 0);
    wait_ps(n);
    check("ps_spacing_mixed", n, 1);

    // Duty 0 never high and duty FF never low, each over three periods.
    set_cfg(16'hFFFF, 16'hFFFF, 8'h00);
    settle();
    hs = 0;
    for (int p = 0; p < 3; p++) begin
      measure(16'hFFFF, 16'h0000, h, b, s0, s1);
      hs += h;
    end
    check("duty00_highs_3p", hs, 0);
    set_cfg(16'hFFFF, 16'hFFFF, 8'hFF);
    settle();
    hs = 0;
    for (int p = 0; p < 3; p++) begin
      measure(16'hFFFF, 16'h0000, h, b, s0, s1);
      hs += h;
    end
    check("dutyFF_highs_3p", hs, 3 * PERIOD);

    // Asynchronous reset mid-run clears out before any clock edge.
    @(negedge clk);
    check("pre_reset_out", {16'h0, out}, 32'hFFFF);
    rst_n = 1'b0;
    #1;
    check("async_reset_out", {16'h0, out}, 32'h0);
    check("async_reset_ps", {31'h0, period_start}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ps(n);
    check("restart_period_start", n, PERIOD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
